// File: rtl/bp_mem_model_pkg.sv
// Shared types for the BlackParrot main-memory model: message codes, size codes,
// controller states and the width-parameterised message struct macro.
`define BP_MEM_MODEL_DECLARE_MSG_S(paddr_w, payload_w, block_w) \
  typedef struct packed { \
    bp_mem_msg_type_e        msg_type; \
    logic [paddr_w-1:0]      addr; \
    bp_mem_size_e            size; \
    logic [payload_w-1:0]    payload; \
  } mem_header_s; \
  typedef struct packed { \
    mem_header_s             header; \
    logic [block_w-1:0]      data; \
  } mem_msg_s;

package bp_mem_model_pkg;

  typedef enum logic [3:0] {
    e_mem_rd    = 4'd0,
    e_mem_wr    = 4'd1,
    e_mem_uc_rd = 4'd2,
    e_mem_uc_wr = 4'd3
  } bp_mem_msg_type_e;

  typedef enum logic [2:0] {
    e_size_1  = 3'd0,
    e_size_2  = 3'd1,
    e_size_4  = 3'd2,
    e_size_8  = 3'd3,
    e_size_16 = 3'd4,
    e_size_32 = 3'd5,
    e_size_64 = 3'd6
  } bp_mem_size_e;

  typedef enum logic [1:0] {
    e_state_idle,
    e_state_wait,
    e_state_resp
  } bp_mem_state_e;

  localparam int default_paddr_width_lp   = 40;
  localparam int default_payload_width_lp = 16;
  localparam int default_block_width_lp   = 512;

  typedef struct packed {
    bp_mem_msg_type_e                     msg_type;
    logic [default_paddr_width_lp-1:0]    addr;
    bp_mem_size_e                         size;
    logic [default_payload_width_lp-1:0]  payload;
  } bp_mem_header_s;

  // Size code 7 has no legal meaning and saturates to a full block.
  function automatic logic [6:0] size_bytes(input logic [2:0] size);
    return (size >= 3'd6) ? 7'd64 : (7'd1 << size);
  endfunction

endpackage

// File: rtl/bp_mem_model_if.sv
// Command/response handshake bundle between a CCE memory port and the memory model.
interface bp_mem_model_if #(parameter int msg_width_p = 575);

  logic [msg_width_p-1:0] mem_cmd_i;
  logic                   mem_cmd_v_i;
  logic                   mem_cmd_ready_o;
  logic [msg_width_p-1:0] mem_resp_o;
  logic                   mem_resp_v_o;
  logic                   mem_resp_yumi_i;

  modport master (
    output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );

  modport slave (
    input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );

endinterface

// File: rtl/bp_mem_model_delay.sv
// Response latency counter: loads a fixed or LFSR-derived latency on start and
// raises done on the cycle the wait should end (immediately when the latency is 0).
module bp_mem_model_delay #(
  parameter int max_latency_p     = 5,
  parameter bit use_max_latency_p = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int cnt_w_lp = $clog2(max_latency_p + 2);

  logic [15:0]         lfsr;
  logic [cnt_w_lp-1:0] count;
  logic [cnt_w_lp-1:0] latency;

  always_comb begin
    latency = cnt_w_lp'(max_latency_p);
    if (!use_max_latency_p)
      latency = cnt_w_lp'({16'b0, lfsr} % 32'(max_latency_p + 1));
  end

  assign done = start ? (latency == '0) : (count == cnt_w_lp'(1));

  // The LFSR free-runs so the drawn latency depends on when the command arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr  <= 16'hACE1;
      count <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (start)
        count <= latency;
      else if (count != '0)
        count <= count - cnt_w_lp'(1);
    end
  end

endmodule

// File: rtl/bp_mem_model.sv
// Single-outstanding main-memory model for the CCE memory side: the access happens
// at the accept edge and the captured response is released after the latency.
module bp_mem_model
  import bp_mem_model_pkg::*;
#(
  parameter int          paddr_width_p      = 40,
  parameter int          block_width_p      = 512,
  parameter int          payload_width_p    = 16,
  parameter int unsigned mem_cap_in_bytes_p = 32'h10000,
  parameter bit          mem_load_p         = 1'b1,
  parameter string       mem_file_p         = "prog.mem",
  parameter logic [31:0] mem_offset_p       = 32'h80000000,
  parameter bit          use_max_latency_p  = 1'b1,
  parameter int          max_latency_p      = 5
) (
  input  logic          clk_i,
  input  logic          reset_i,
  bp_mem_model_if.slave mem_if
);

  `BP_MEM_MODEL_DECLARE_MSG_S(paddr_width_p, payload_width_p, block_width_p)

  localparam int idx_w_lp       = $clog2(mem_cap_in_bytes_p);
  localparam int block_bytes_lp = block_width_p / 8;
  localparam bit preload_lp     = mem_load_p && (mem_file_p != "");

  logic [7:0] mem     [mem_cap_in_bytes_p];
  logic       written [mem_cap_in_bytes_p];

  bp_mem_state_e            state;
  mem_msg_s                 cmd;
  mem_msg_s                 resp_msg;
  logic                     resp_valid;
  logic [idx_w_lp-1:0]      idx;
  logic [idx_w_lp-1:0]      base;
  logic [6:0]               nbytes;
  logic                     is_read;
  logic                     is_write;
  logic                     accept;
  logic                     done;
  logic [block_width_p-1:0] rd_data;

  assign cmd = mem_if.mem_cmd_i;

  assign is_read  = (cmd.header.msg_type == e_mem_rd) || (cmd.header.msg_type == e_mem_uc_rd);
  assign is_write = (cmd.header.msg_type == e_mem_wr) || (cmd.header.msg_type == e_mem_uc_wr);
  assign nbytes   = ((cmd.header.msg_type == e_mem_rd) || (cmd.header.msg_type == e_mem_wr))
                    ? 7'd64 : size_bytes(cmd.header.size);

  // Capacity is a power of two, so truncation gives the wrap-around window index.
  assign idx    = idx_w_lp'(cmd.header.addr - paddr_width_p'(mem_offset_p));
  assign base   = idx & ~idx_w_lp'(nbytes - 7'd1);
  assign accept = (state == e_state_idle) && mem_if.mem_cmd_v_i;

  always_comb begin
    rd_data = '0;
    if (is_read) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (b < int'(nbytes) && (preload_lp || written[base + idx_w_lp'(b)]))
          rd_data[8*b +: 8] = mem[base + idx_w_lp'(b)];
      end
    end
  end

  // Storage survives reset; only the handshake state is cleared.
  always_ff @(posedge clk_i) begin
    if (accept && is_write) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (b < int'(nbytes)) begin
          mem[base + idx_w_lp'(b)]     <= cmd.data[8*b +: 8];
          written[base + idx_w_lp'(b)] <= 1'b1;
        end
      end
    end
  end

  bp_mem_model_delay #(
    .max_latency_p    (max_latency_p),
    .use_max_latency_p(use_max_latency_p)
  ) delay (
    .clk  (clk_i),
    .rst_n(reset_i),
    .start(accept),
    .done (done)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= e_state_idle;
      resp_valid <= 1'b0;
      resp_msg   <= '0;
    end else begin
      case (state)
        e_state_idle: begin
          if (accept) begin
            resp_msg.header <= cmd.header;
            resp_msg.data   <= rd_data;
            resp_valid      <= done;
            state           <= done ? e_state_resp : e_state_wait;
          end
        end
        e_state_wait: begin
          if (done) begin
            resp_valid <= 1'b1;
            state      <= e_state_resp;
          end
        end
        e_state_resp: begin
          if (mem_if.mem_resp_yumi_i) begin
            resp_valid <= 1'b0;
            state      <= e_state_idle;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= e_state_idle;
        end
      endcase
    end
  end

  assign mem_if.mem_cmd_ready_o = (state == e_state_idle) && reset_i;
  assign mem_if.mem_resp_o      = resp_msg;
  assign mem_if.mem_resp_v_o    = resp_valid;

endmodule

// File: tb/tb_bp_mem_model.sv
// Directed bench for bp_mem_model: a fixed-latency instance for data/protocol checks
// and a random-latency instance for the latency range sweep.
module tb_bp_mem_model;
  import bp_mem_model_pkg::*;

  localparam int msg_w = $bits(bp_mem_header_s) + 512;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bp_mem_model_if #(.msg_width_p(msg_w)) fif ();
  bp_mem_model_if #(.msg_width_p(msg_w)) rif ();

  bp_mem_model #(
    .mem_load_p(1'b0), .use_max_latency_p(1'b1), .max_latency_p(5)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .mem_if(fif)
  );

  bp_mem_model #(
    .mem_load_p(1'b0), .use_max_latency_p(1'b0), .max_latency_p(5)
  ) dut_rand (
    .clk_i(clk), .reset_i(reset_n), .mem_if(rif)
  );

  int total_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;
  logic [511:0] pattern;

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit rnd, input logic [3:0] t, input logic [39:0] addr,
                                input logic [2:0] size, input logic [15:0] payload,
                                input logic [511:0] data);
    int   guard = 0;
    logic rdy;
    rdy = rnd ? rif.mem_cmd_ready_o : fif.mem_cmd_ready_o;
    while (!rdy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
      rdy = rnd ? rif.mem_cmd_ready_o : fif.mem_cmd_ready_o;
    end
    check_output("cmd_ready", 512'(rdy), 512'(1));
    if (rnd) begin
      rif.mem_cmd_i   = {t, addr, size, payload, data};
      rif.mem_cmd_v_i = 1'b1;
    end else begin
      fif.mem_cmd_i   = {t, addr, size, payload, data};
      fif.mem_cmd_v_i = 1'b1;
    end
    @(posedge clk); #1;
    rif.mem_cmd_v_i = 1'b0;
    fif.mem_cmd_v_i = 1'b0;
  endtask

  // Counts edges from the accept edge (1) until the response is visible.
  task automatic wait_resp(input bit rnd, output int lat);
    lat = 1;
    while (!(rnd ? rif.mem_resp_v_o : fif.mem_resp_v_o) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_resp(input bit rnd);
    if (rnd) rif.mem_resp_yumi_i = 1'b1;
    else     fif.mem_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    rif.mem_resp_yumi_i = 1'b0;
    fif.mem_resp_yumi_i = 1'b0;
  endtask

  task automatic check_txn(input string tag, input logic [3:0] t, input logic [39:0] addr,
                           input logic [2:0] size, input logic [15:0] payload,
                           input logic [511:0] data, input logic [511:0] exp_data);
    int lat;
    apply_stimulus(1'b0, t, addr, size, payload, data);
    wait_resp(1'b0, lat);
    check_output({tag, "_lat"}, 512'(lat), 512'(6));
    check_output({tag, "_data"}, fif.mem_resp_o[511:0], exp_data);
    check_output({tag, "_hdr"}, 512'(fif.mem_resp_o[msg_w-1:512]), 512'({t, addr, size, payload}));
    take_resp(1'b0);
    check_output({tag, "_ready_after"}, 512'(fif.mem_cmd_ready_o), 512'(1));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int lo = 99;
    int hi = -1;
    fif.mem_cmd_i = '0; fif.mem_cmd_v_i = 1'b0; fif.mem_resp_yumi_i = 1'b0;
    rif.mem_cmd_i = '0; rif.mem_cmd_v_i = 1'b0; rif.mem_resp_yumi_i = 1'b0;
    for (int b = 0; b < 64; b++) pattern[8*b +: 8] = 8'(b);

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ready", 512'(fif.mem_cmd_ready_o), 512'(0));
    check_output("reset_resp_v", 512'(fif.mem_resp_v_o), 512'(0));
    check_output("reset_resp_data", fif.mem_resp_o[511:0], 512'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_output("release_ready", 512'(fif.mem_cmd_ready_o), 512'(1));

    // Load bytes 00..3F at the window base, then read them back as a block.
    check_txn("preload_wr", 4'd1, 40'h0080000000, 3'd6, 16'h1111, pattern, 512'(0));
    check_txn("block_rd", 4'd0, 40'h0080000000, 3'd6, 16'h2222, '0, pattern);

    check_txn("uc_wr8", 4'd3, 40'h0080000108, 3'd3, 16'h3333, 512'(64'h1122334455667788), 512'(0));
    check_txn("uc_rd8", 4'd2, 40'h0080000108, 3'd3, 16'h4444, '0, 512'(64'h1122334455667788));
    check_txn("uc_rd1", 4'd2, 40'h0080000003, 3'd0, 16'h5555, '0, 512'(8'h03));
    check_txn("uc_rd4_align", 4'd2, 40'h0080000006, 3'd2, 16'h6666, '0, 512'(32'h07060504));

    check_txn("wrap_rd", 4'd0, 40'h0080010000, 3'd6, 16'h7777, '0, pattern);
    check_txn("wrap_uc_rd1", 4'd2, 40'h0080010005, 3'd0, 16'h8888, '0, 512'(8'h05));
    check_txn("bad_type", 4'd5, 40'h0080000000, 3'd6, 16'h9999, {512{1'b1}}, 512'(0));
    check_txn("bad_type_nowrite", 4'd2, 40'h0080000000, 3'd0, 16'hAAAA, '0, 512'(0));
    check_txn("uc_rd_size7", 4'd2, 40'h0080000010, 3'd7, 16'hBBBB, '0, pattern);

    // Response must hold while the consumer stalls.
    apply_stimulus(1'b0, 4'd0, 40'h0080000000, 3'd6, 16'hCCCC, '0);
    wait_resp(1'b0, lat);
    check_output("hold_lat", 512'(lat), 512'(6));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_output("hold_resp_v", 512'(fif.mem_resp_v_o), 512'(1));
      check_output("hold_data", fif.mem_resp_o[511:0], pattern);
      check_output("hold_ready", 512'(fif.mem_cmd_ready_o), 512'(0));
    end
    take_resp(1'b0);
    check_output("hold_ready_after", 512'(fif.mem_cmd_ready_o), 512'(1));

    // Reset while waiting: response is dropped, the committed write survives.
    apply_stimulus(1'b0, 4'd3, 40'h0080000200, 3'd0, 16'hDDDD, 512'(8'hA5));
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check_output("midreset_ready", 512'(fif.mem_cmd_ready_o), 512'(0));
    check_output("midreset_resp_v", 512'(fif.mem_resp_v_o), 512'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_output("no_stale_resp", 512'(fif.mem_resp_v_o), 512'(0));
      check_output("post_reset_ready", 512'(fif.mem_cmd_ready_o), 512'(1));
    end
    check_txn("committed_wr", 4'd2, 40'h0080000200, 3'd0, 16'hEEEE, '0, 512'(8'hA5));

    for (int i = 0; i < 200; i++) begin
      apply_stimulus(1'b1, 4'd0, 40'h0080000000 + 40'(i * 64), 3'd6, 16'(i), '0);
      wait_resp(1'b1, lat);
      check_output("rand_lat_range", 512'((lat >= 1) && (lat <= 6)), 512'(1));
      if (lat < lo) lo = lat;
      if (lat > hi) hi = lat;
      take_resp(1'b1);
    end
    check_output("rand_lat_spread", 512'(lo != hi), 512'(1));

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
